// File: rtl/piso_shift_reg_if.sv
// Load and serial-output handshake bundle for the parallel-in, serial-out register.
interface piso_shift_reg_if #(
    parameter int unsigned DATAWIDTH = 8
);
    logic [DATAWIDTH-1:0] d;
    logic                 load_valid;
    logic                 load_ready;
    logic                 sout;
    logic                 sout_valid;
    logic                 sout_ready;
    logic                 last;
    logic                 busy;

    modport master (
        output d, load_valid, sout_ready,
        input  load_ready, sout, sout_valid, last, busy
    );

    modport slave (
        input  d, load_valid, sout_ready,
        output load_ready, sout, sout_valid, last, busy
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out register: one word loaded through load_valid/load_ready,
// drained one bit per sout_valid/sout_ready beat in the selected bit order.
module piso_shift_reg #(
    parameter int unsigned DATAWIDTH = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    piso_shift_reg_if.slave  bus
);
    localparam int unsigned CNT_W = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [DATAWIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   beat;

    assign beat = (state_q == SHIFT) && bus.sout_ready;

    // Next-state: capture on load in IDLE, shift toward the output end on each beat.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    shreg_d = bus.d;
                    cnt_d   = CNT_W'(DATAWIDTH - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat) begin
                    if (cnt_q == CNT_W'(0)) begin
                        state_d = IDLE;
                    end else begin
                        if (MSB_FIRST) begin
                            shreg_d = {shreg_q[DATAWIDTH-2:0], 1'b0};
                        end else begin
                            shreg_d = {1'b0, shreg_q[DATAWIDTH-1:1]};
                        end
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only; gated so IDLE shows the reset values.
    assign bus.load_ready = (state_q == IDLE);
    assign bus.sout_valid = (state_q == SHIFT);
    assign bus.busy       = (state_q == SHIFT);
    assign bus.sout       = (state_q == SHIFT) &&
                            (MSB_FIRST ? shreg_q[DATAWIDTH-1] : shreg_q[0]);
    assign bus.last       = (state_q == SHIFT) && (cnt_q == CNT_W'(0));

endmodule
